// File: rtl/priv_1_12_trap_sequencer_pkg.sv
// Shared privilege-block types and constants for the trap entry/return sequencer.
package priv_1_12_trap_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDrain    = 2'd1,
    StSettle   = 2'd2,
    StRedirect = 2'd3
  } trap_seq_state_t;

  typedef enum logic {
    KindTrap = 1'b0,
    KindRet  = 1'b1
  } trap_kind_t;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

endpackage

// File: rtl/priv_1_12_trap_target.sv
// Combinational redirect target from kind, mtvec, mcause and mepc.
// Vectored interrupt dispatch is built only when PRIV_VECTORED_TRAP_EN is defined.
module priv_1_12_trap_target
  import priv_1_12_trap_sequencer_pkg::*;
(
  input  trap_kind_t  kind_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] mepc_i,
  output logic [31:0] target_o
);

  logic [31:0] base;

  assign base = {mtvec_i[31:2], 2'b00};

`ifdef PRIV_VECTORED_TRAP_EN
  logic unused_bits;
  assign unused_bits = ^{mepc_i[1:0], mcause_i[30]};

  always_comb begin
    target_o = base;
    if (kind_i == KindRet) begin
      target_o = {mepc_i[31:2], 2'b00};
    end else if (mtvec_i[1:0] == MTVEC_MODE_VECTORED && mcause_i[31]) begin
      // cause << 2 truncated to 32 bits; wrap past 2^32 is intentional
      target_o = base + {mcause_i[29:0], 2'b00};
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{mepc_i[1:0], mtvec_i[1:0], mcause_i};

  always_comb begin
    target_o = base;
    if (kind_i == KindRet) begin
      target_o = {mepc_i[31:2], 2'b00};
    end
  end
`endif

endmodule

// File: rtl/priv_1_12_trap_sequencer.sv
// Trap entry / mret sequencer: stall fetch, drain, settle one cycle, then hold a redirect
// until fetch acknowledges. Vectored dispatch is enabled by PRIV_VECTORED_TRAP_EN.
module priv_1_12_trap_sequencer
  import priv_1_12_trap_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_MAX = 32
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        intr,
  input  logic        mret,
  input  logic        sret,
  input  logic        uret,
  input  logic        pipe_clear,
  input  logic [31:0] curr_mtvec,
  input  logic [31:0] curr_mcause,
  input  logic [31:0] curr_mepc,
  input  logic        redirect_ack,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        hold_fetch,
  output logic        busy,
  output logic        trap_taken,
  output logic        ret_taken,
  output logic        drain_err
);

  // Counter saturates one above the error threshold so drain_err fires only once.
  localparam int unsigned CntW = $clog2(DRAIN_MAX + 1);
  localparam logic [CntW-1:0] CntErr = CntW'(DRAIN_MAX - 1);
  localparam logic [CntW-1:0] CntSat = CntW'(DRAIN_MAX);

  trap_seq_state_t state_q, state_d;
  trap_kind_t      kind_q, kind_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     target;

  logic unused_xret;
  assign unused_xret = ^{sret, uret};

  priv_1_12_trap_target u_target (
    .kind_i   (kind_q),
    .mtvec_i  (curr_mtvec),
    .mcause_i (curr_mcause),
    .mepc_i   (curr_mepc),
    .target_o (target)
  );

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    drain_err  = 1'b0;
    trap_taken = 1'b0;
    ret_taken  = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (intr) begin
          state_d = StDrain;
          kind_d  = KindTrap;
        end else if (mret) begin
          state_d = StDrain;
          kind_d  = KindRet;
        end
      end
      StDrain: begin
        if (pipe_clear) begin
          state_d = StSettle;
          cnt_d   = '0;
        end else begin
          drain_err = (cnt_q == CntErr);
          if (cnt_q != CntSat) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StSettle: begin
        pc_d    = target;
        state_d = StRedirect;
      end
      StRedirect: begin
        if (redirect_ack) begin
          state_d    = StIdle;
          trap_taken = (kind_q == KindTrap);
          ret_taken  = (kind_q == KindRet);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= StIdle;
      kind_q  <= KindTrap;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign hold_fetch = (state_q != StIdle);
  assign insert_pc  = (state_q == StRedirect);
  assign priv_pc    = pc_q;

endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// Self-checking bench for priv_1_12_trap_sequencer with an expected-redirect scoreboard.
module tb_priv_1_12_trap_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        intr, mret, sret, uret, pipe_clear, redirect_ack;
  logic [31:0] curr_mtvec, curr_mcause, curr_mepc;
  logic        insert_pc, hold_fetch, busy, trap_taken, ret_taken, drain_err;
  logic [31:0] priv_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic        is_ret;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef PRIV_VECTORED_TRAP_EN
  localparam logic [31:0] ExpVec7 = 32'h0000_101C;
  localparam logic [31:0] ExpVec3 = 32'h0000_100C;
`else
  localparam logic [31:0] ExpVec7 = 32'h0000_1000;
  localparam logic [31:0] ExpVec3 = 32'h0000_1000;
`endif

  priv_1_12_trap_sequencer #(
    .DRAIN_MAX (4)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .intr         (intr),
    .mret         (mret),
    .sret         (sret),
    .uret         (uret),
    .pipe_clear   (pipe_clear),
    .curr_mtvec   (curr_mtvec),
    .curr_mcause  (curr_mcause),
    .curr_mepc    (curr_mepc),
    .redirect_ack (redirect_ack),
    .insert_pc    (insert_pc),
    .priv_pc      (priv_pc),
    .hold_fetch   (hold_fetch),
    .busy         (busy),
    .trap_taken   (trap_taken),
    .ret_taken    (ret_taken),
    .drain_err    (drain_err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_insert(input int budget, output bit ok);
    int n = 0;
    while (!insert_pc && n < budget) begin
      step();
      n++;
    end
    ok = insert_pc;
  endtask

  task automatic test_reset();
    exp_t e;
    nRST = 1'b0;
    step();
    step();
    e = '0;
    checks++;
    if ({insert_pc, hold_fetch, busy, trap_taken, ret_taken, drain_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {insert_pc, hold_fetch, busy, trap_taken, ret_taken, drain_err});
    end
    checks++;
    if (priv_pc !== e.pc) begin
      errors++;
      $display("FAIL reset_pc: got %h expected %h", priv_pc, e.pc);
    end
    nRST = 1'b1;
    step();
  endtask

  task automatic test_trap_vectored();
    exp_t e;
    curr_mtvec  = 32'h0000_1001;
    curr_mcause = 32'h8000_0007;
    pipe_clear  = 1'b1;
    sb_q.push_back('{pc: ExpVec7, is_ret: 1'b0});
    intr = 1'b1;
    step();
    intr = 1'b0;
    checks++;
    if (busy !== 1'b1 || hold_fetch !== 1'b1 || insert_pc !== 1'b0) begin
      errors++;
      $display("FAIL trap_drain_cycle1: got busy=%b hold=%b ins=%b expected 1 1 0",
               busy, hold_fetch, insert_pc);
    end
    step();
    checks++;
    if (insert_pc !== 1'b0 || hold_fetch !== 1'b1) begin
      errors++;
      $display("FAIL trap_settle_cycle2: got ins=%b hold=%b expected 0 1", insert_pc, hold_fetch);
    end
    step();
    checks++;
    if (insert_pc !== 1'b1) begin
      errors++;
      $display("FAIL trap_latency_cycle3: got insert_pc=%b expected 1", insert_pc);
    end
    redirect_ack = 1'b1;
    #1;
    e = sb_q.pop_front();
    checks++;
    if (priv_pc !== e.pc) begin
      errors++;
      $display("FAIL trap_vectored_pc: got %h expected %h", priv_pc, e.pc);
    end
    checks++;
    if (trap_taken !== 1'b1 || ret_taken !== 1'b0) begin
      errors++;
      $display("FAIL trap_pulse: got trap=%b ret=%b expected 1 0", trap_taken, ret_taken);
    end
    step();
    redirect_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || trap_taken !== 1'b0) begin
      errors++;
      $display("FAIL trap_back_idle: got busy=%b trap=%b expected 0 0", busy, trap_taken);
    end
  endtask

  task automatic test_mret();
    exp_t e;
    bit   ok;
    curr_mepc  = 32'h0000_2006;
    pipe_clear = 1'b0;
    sb_q.push_back('{pc: 32'h0000_2004, is_ret: 1'b1});
    mret = 1'b1;
    step();
    mret = 1'b0;
    for (int i = 0; i < 4; i++) step();
    pipe_clear = 1'b1;
    wait_insert(8, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mret_timeout: got insert_pc=%b expected 1", insert_pc);
    end
    redirect_ack = 1'b1;
    #1;
    e = sb_q.pop_front();
    checks++;
    if (priv_pc !== e.pc) begin
      errors++;
      $display("FAIL mret_pc: got %h expected %h", priv_pc, e.pc);
    end
    checks++;
    if (ret_taken !== e.is_ret || trap_taken !== 1'b0) begin
      errors++;
      $display("FAIL mret_pulse: got ret=%b trap=%b expected 1 0", ret_taken, trap_taken);
    end
    step();
    redirect_ack = 1'b0;
  endtask

  task automatic test_priority();
    exp_t e;
    bit   ok;
    curr_mtvec  = 32'h0000_1001;
    curr_mcause = 32'h0000_0002;
    curr_mepc   = 32'h0000_3000;
    pipe_clear  = 1'b1;
    sb_q.push_back('{pc: 32'h0000_1000, is_ret: 1'b0});
    intr = 1'b1;
    mret = 1'b1;
    step();
    intr = 1'b0;
    mret = 1'b0;
    wait_insert(6, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL prio_timeout: got insert_pc=%b expected 1", insert_pc);
    end
    redirect_ack = 1'b1;
    #1;
    e = sb_q.pop_front();
    checks++;
    if (priv_pc !== e.pc) begin
      errors++;
      $display("FAIL prio_pc: got %h expected %h", priv_pc, e.pc);
    end
    checks++;
    if (trap_taken !== 1'b1 || ret_taken !== 1'b0) begin
      errors++;
      $display("FAIL prio_kind: got trap=%b ret=%b expected 1 0", trap_taken, ret_taken);
    end
    step();
    redirect_ack = 1'b0;
  endtask

  task automatic test_drain_timeout();
    exp_t e;
    bit   ok;
    int   pulses = 0;
    int   first  = 0;
    curr_mtvec  = 32'h0000_1001;
    curr_mcause = 32'h8000_0007;
    pipe_clear  = 1'b0;
    sb_q.push_back('{pc: ExpVec7, is_ret: 1'b0});
    intr = 1'b1;
    step();
    intr = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (drain_err === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
      step();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL drain_err_count: got %0d expected 1", pulses);
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL drain_err_cycle: got %0d expected 4", first);
    end
    checks++;
    if (busy !== 1'b1 || insert_pc !== 1'b0) begin
      errors++;
      $display("FAIL drain_still_waiting: got busy=%b ins=%b expected 1 0", busy, insert_pc);
    end
    pipe_clear = 1'b1;
    wait_insert(6, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_complete_timeout: got insert_pc=%b expected 1", insert_pc);
    end
    redirect_ack = 1'b1;
    #1;
    e = sb_q.pop_front();
    checks++;
    if (priv_pc !== e.pc || trap_taken !== 1'b1) begin
      errors++;
      $display("FAIL drain_complete: got pc=%h trap=%b expected %h 1", priv_pc, trap_taken, e.pc);
    end
    step();
    redirect_ack = 1'b0;
  endtask

  task automatic test_ack_stall();
    exp_t e;
    bit   ok;
    curr_mtvec  = 32'h0000_1001;
    curr_mcause = 32'h8000_0003;
    pipe_clear  = 1'b1;
    sb_q.push_back('{pc: ExpVec3, is_ret: 1'b0});
    intr = 1'b1;
    step();
    intr = 1'b0;
    wait_insert(6, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout: got insert_pc=%b expected 1", insert_pc);
    end
    e = sb_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      curr_mcause = $urandom;
      #1;
      checks++;
      if (insert_pc !== 1'b1 || priv_pc !== e.pc || trap_taken !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got ins=%b pc=%h trap=%b expected 1 %h 0",
                 i, insert_pc, priv_pc, trap_taken, e.pc);
      end
      step();
    end
    redirect_ack = 1'b1;
    #1;
    checks++;
    if (trap_taken !== 1'b1 || priv_pc !== e.pc) begin
      errors++;
      $display("FAIL stall_ack: got trap=%b pc=%h expected 1 %h", trap_taken, priv_pc, e.pc);
    end
    step();
    redirect_ack = 1'b0;
  endtask

  task automatic test_reset_mid_redirect();
    exp_t e;
    bit   ok;
    curr_mtvec  = 32'h0000_4000;
    curr_mcause = 32'h0000_0004;
    pipe_clear  = 1'b1;
    intr = 1'b1;
    step();
    intr = 1'b0;
    wait_insert(6, ok);
    checks++;
    if (!ok || priv_pc !== 32'h0000_4000) begin
      errors++;
      $display("FAIL rst_pre_redirect: got ins=%b pc=%h expected 1 00004000", insert_pc, priv_pc);
    end
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    checks++;
    if ({insert_pc, hold_fetch, busy, trap_taken, ret_taken, drain_err} !== 6'b0
        || priv_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_redirect: got flags=%b pc=%h expected 000000 00000000",
               {insert_pc, hold_fetch, busy, trap_taken, ret_taken, drain_err}, priv_pc);
    end
    step();
    sb_q.push_back('{pc: 32'h0000_4000, is_ret: 1'b0});
    intr = 1'b1;
    step();
    intr = 1'b0;
    wait_insert(6, ok);
    redirect_ack = 1'b1;
    #1;
    e = sb_q.pop_front();
    checks++;
    if (!ok || priv_pc !== e.pc || trap_taken !== 1'b1) begin
      errors++;
      $display("FAIL rst_recover: got ins=%b pc=%h trap=%b expected 1 %h 1",
               insert_pc, priv_pc, trap_taken, e.pc);
    end
    step();
    redirect_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    curr_mtvec  = 32'h0000_1001;
    curr_mcause = 32'h0000_0005;
    pipe_clear  = 1'b1;
    sb_q.push_back('{pc: 32'h0000_1000, is_ret: 1'b0});
    sb_q.push_back('{pc: 32'h0000_1000, is_ret: 1'b0});
    intr = 1'b1;
    step();
    wait_insert(6, ok);
    redirect_ack = 1'b1;
    #1;
    e = sb_q.pop_front();
    checks++;
    if (!ok || priv_pc !== e.pc || trap_taken !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got ins=%b pc=%h trap=%b expected 1 %h 1",
               insert_pc, priv_pc, trap_taken, e.pc);
    end
    step();
    redirect_ack = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy);
    end
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%b expected 1", busy);
    end
    intr = 1'b0;
    wait_insert(6, ok);
    redirect_ack = 1'b1;
    #1;
    e = sb_q.pop_front();
    checks++;
    if (!ok || priv_pc !== e.pc || trap_taken !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got ins=%b pc=%h trap=%b expected 1 %h 1",
               insert_pc, priv_pc, trap_taken, e.pc);
    end
    step();
    redirect_ack = 1'b0;
  endtask

  task automatic test_ignored_xret();
    sret = 1'b1;
    uret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || hold_fetch !== 1'b0) begin
        errors++;
        $display("FAIL xret_ignored_%0d: got busy=%b hold=%b expected 0 0", i, busy, hold_fetch);
      end
    end
    sret = 1'b0;
    uret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST         = 1'b0;
    intr         = 1'b0;
    mret         = 1'b0;
    sret         = 1'b0;
    uret         = 1'b0;
    pipe_clear   = 1'b0;
    redirect_ack = 1'b0;
    curr_mtvec   = '0;
    curr_mcause  = '0;
    curr_mepc    = '0;

    test_reset();
    test_trap_vectored();
    test_mret();
    test_priority();
    test_drain_timeout();
    test_ack_stall();
    test_reset_mid_redirect();
    test_back_to_back();
    test_ignored_xret();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
